// File: rtl/spi_sched_pkg.sv
// Shared state encoding, request record and width defaults for the SPI transaction scheduler.
package spi_sched_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } spi_req_t;

endpackage

// File: rtl/spi_req_fifo.sv
// Request FIFO for the SPI scheduler; pointers carry one extra wrap bit to tell full from empty.
module spi_req_fifo
  import spi_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = spi_req_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  ENTRY_T push_data_i,
  input  logic   pop_i,
  output ENTRY_T head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  ENTRY_T mem_q [DEPTH];

  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q;
  logic [PTR_W:0] rd_ptr_d;
  logic           do_push;
  logic           do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Queues host requests, runs them one at a time on the SPI top by releasing its reset, returns responses.
// Define SPI_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_wr_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              spi_rst_o,
  output logic              spi_wr_o,
  output logic [ADDR_W-1:0] spi_addr_o,
  output logic [DATA_W-1:0] spi_din_o,
  input  logic [DATA_W-1:0] spi_dout_i,
  input  logic              spi_done_i,
  input  logic              spi_err_i
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_txn_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t         push_entry;
  req_t         head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         wd_expired;

  sched_state_t      state_q;
  logic              ready_en_q;
  logic              spi_rst_q;
  logic              spi_wr_q;
  logic [ADDR_W-1:0] spi_addr_q;
  logic [DATA_W-1:0] spi_din_q;
  logic              rsp_valid_q;
  logic              rsp_wr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  // ready_en_q keeps req_ready low for the reset cycle itself.
  assign req_ready_o = ready_en_q && !fifo_full;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign push_entry  = '{wr: req_wr_i, addr: req_addr_i, data: req_data_i};

  spi_req_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (req_t)
  ) u_req_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = 1;

  logic [WD_W-1:0] wd_cnt_q;

  // Down-counter reloads outside WAIT; reaching zero marks the last WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != WAIT) begin
      wd_cnt_q <= WD_LOAD;
    end else if (wd_cnt_q != '0) begin
      wd_cnt_q <= wd_cnt_q - WD_ONE;
    end
  end

  assign wd_expired = (state_q == WAIT) && (wd_cnt_q == '0);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_en_q  <= 1'b0;
      spi_rst_q   <= 1'b1;
      spi_wr_q    <= 1'b0;
      spi_addr_q  <= '0;
      spi_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            spi_wr_q   <= head.wr;
            spi_addr_q <= head.addr;
            spi_din_q  <= head.data;
            spi_rst_q  <= 1'b0;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // err has priority over done, and either beats the watchdog on its last cycle.
          if (spi_done_i || spi_err_i) begin
            rsp_wr_q    <= spi_wr_q;
            rsp_err_q   <= spi_err_i;
            rsp_data_q  <= (!spi_wr_q && !spi_err_i) ? spi_dout_i : '0;
            rsp_valid_q <= 1'b1;
            spi_rst_q   <= 1'b1;
            state_q     <= RESP;
          end else if (wd_expired) begin
            rsp_wr_q    <= spi_wr_q;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            spi_rst_q   <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_wr_o    = rsp_wr_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign spi_rst_o   = spi_rst_q;
  assign spi_wr_o    = spi_wr_q;
  assign spi_addr_o  = spi_addr_q;
  assign spi_din_o   = spi_din_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench for spi_txn_scheduler with a behavioural SPI device and an in-order response model.
`timescale 1ns/1ps
module tb_spi_txn_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int TO    = 16;

  typedef struct {
    bit       wr;
    bit [7:0] addr;
    bit [7:0] data;
    bit       err;
    int       lat;
    bit       hang;
  } txn_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready_o;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid_o;
  logic          rsp_ready;
  logic          rsp_wr_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          spi_rst_o;
  logic          spi_wr_o;
  logic [AW-1:0] spi_addr_o;
  logic [DW-1:0] spi_din_o;
  logic [DW-1:0] spi_dout;
  logic          spi_done;
  logic          spi_err;

  int   checks = 0;
  int   errors = 0;
  int   rsp_seen = 0;
  bit   spurious_en = 0;
  bit   rand_rdy = 0;
  txn_t launch_q[$];
  txn_t exp_q[$];
  bit [7:0] dev_mem [256];
  bit [7:0] ref_mem [256];

  spi_txn_scheduler #(
    .DEPTH          (DEPTH),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_wr_o    (rsp_wr_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .spi_rst_o   (spi_rst_o),
    .spi_wr_o    (spi_wr_o),
    .spi_addr_o  (spi_addr_o),
    .spi_din_o   (spi_din_o),
    .spi_dout_i  (spi_dout),
    .spi_done_i  (spi_done),
    .spi_err_i   (spi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic txn_t mk(input bit wr, input bit [7:0] addr, input bit [7:0] data,
                              input bit err, input int lat, input bit hang);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.err = err; t.lat = lat; t.hang = hang;
    return t;
  endfunction

  function automatic logic [29:0] outs();
    return {req_ready_o, rsp_valid_o, rsp_wr_o, rsp_data_o, rsp_err_o,
            spi_rst_o, spi_wr_o, spi_addr_o, spi_din_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural SPI device: starts when its reset is released, answers after lat cycles.
  initial begin : spi_model
    txn_t          cur;
    bit            active;
    bit            fired;
    int            lat;
    logic [16:0]   snap;
    spi_done = 1'b0; spi_err = 1'b0; spi_dout = '0;
    active = 0; fired = 0; lat = 0; snap = '0;
    cur = mk(0, 0, 0, 0, 1, 1);
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      spi_err  = 1'b0;
      if (rst || spi_rst_o) begin
        active = 0;
        if (!rst && spurious_en && $urandom_range(3) == 0) begin
          spi_done = 1'($urandom_range(1));
          spi_err  = !spi_done;
          spi_dout = 8'($urandom);
        end
      end else if (!active) begin
        active = 1; fired = 0;
        checks++;
        if (launch_q.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected: got addr=%h with nothing queued", spi_addr_o);
          cur = mk(0, 0, 0, 0, 1, 1);
        end else begin
          cur = launch_q.pop_front();
          if ({spi_wr_o, spi_addr_o, spi_din_o} !== {cur.wr, cur.addr, cur.data}) begin
            errors++;
            $display("FAIL launch_fields: got wr=%b addr=%h din=%h want wr=%b addr=%h din=%h",
                     spi_wr_o, spi_addr_o, spi_din_o, cur.wr, cur.addr, cur.data);
          end
        end
        snap = {spi_wr_o, spi_addr_o, spi_din_o};
        lat  = cur.lat;
      end else begin
        checks++;
        if ({spi_wr_o, spi_addr_o, spi_din_o} !== snap) begin
          errors++;
          $display("FAIL spi_stable: got %h want %h", {spi_wr_o, spi_addr_o, spi_din_o}, snap);
        end
        if (!fired && !cur.hang) begin
          if (lat > 1) lat--;
          else begin
            fired = 1;
            if (cur.err) begin
              spi_err  = 1'b1;
              spi_done = 1'($urandom_range(1));
              spi_dout = 8'($urandom);
            end else begin
              spi_done = 1'b1;
              if (cur.wr) begin
                dev_mem[cur.addr] = cur.data;
                spi_dout = 8'($urandom);
              end else begin
                spi_dout = dev_mem[cur.addr];
              end
            end
          end
        end
      end
    end
  end

  // Reference: responses retire in push order; memory reflects only successful writes.
  initial begin : scoreboard
    txn_t        t;
    logic [9:0]  got;
    logic [9:0]  exp;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid_o && rsp_ready) begin
        checks++;
        rsp_seen++;
        got = {rsp_wr_o, rsp_err_o, rsp_data_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got wr/err/data=%h with nothing outstanding", got);
        end else begin
          t = exp_q.pop_front();
          if (t.err || t.hang) exp = {t.wr, 1'b1, 8'h00};
          else if (t.wr) begin
            ref_mem[t.addr] = t.data;
            exp = {1'b1, 1'b0, 8'h00};
          end else exp = {1'b0, 1'b0, ref_mem[t.addr]};
          if (got !== exp) begin
            errors++;
            $display("FAIL rsp_fields: addr=%h got wr/err/data=%h want %h", t.addr, got, exp);
          end
        end
      end
    end
  end

  initial begin : rand_host
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(1));
    end
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push_req(input txn_t t);
    int n = 0;
    req_valid = 1'b1; req_wr = t.wr; req_addr = t.addr; req_data = t.data;
    while (!req_ready_o) begin
      tick();
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL push_timeout: req_ready=%b want 1 within 300 cycles", req_ready_o);
        req_valid = 1'b0;
        return;
      end
    end
    tick();
    launch_q.push_back(t);
    exp_q.push_back(t);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0) begin
      tick();
      n++;
      if (n > budget) begin
        checks++; errors++;
        $display("FAIL drain_timeout: outstanding=%0d want 0", exp_q.size());
        exp_q.delete(); launch_q.delete();
        return;
      end
    end
    tick();
  endtask

  task automatic wait_launch(output bit ok);
    int n = 0;
    ok = 1;
    while (spi_rst_o) begin
      tick();
      n++;
      if (n > 100) begin
        checks++; errors++; ok = 0;
        $display("FAIL launch_timeout: spi_rst=%b want 0", spi_rst_o);
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [29:0] want;
    want = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    rst = 1'b1; tick(); tick();
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", outs(), want);
    end
    rst = 1'b0; tick();
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_write_read();
    int base = rsp_seen;
    rsp_ready = 1'b1;
    push_req(mk(1, 8'h05, 8'hA5, 0, 2, 0));
    push_req(mk(0, 8'h05, 8'h3C, 0, 3, 0));
    wait_drain(200);
    checks++;
    if (rsp_seen - base !== 2) begin
      errors++;
      $display("FAIL write_read_count: got %0d want 2", rsp_seen - base);
    end
  endtask

  task automatic test_fill();
    int base = rsp_seen;
    bit held = 1;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_req(mk(1, 8'(i), 8'(i * 17), 0, 1, 0));
    push_req(mk(0, 8'h03, 8'h00, 0, 1, 0));
    repeat (10) tick();
    checks++;
    if ({req_ready_o, rsp_valid_o, spi_rst_o} !== 3'b011) begin
      errors++;
      $display("FAIL fill_full: got ready/valid/spi_rst=%b want 011", {req_ready_o, rsp_valid_o, spi_rst_o});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_ready_o !== 1'b0) held = 0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL fill_hold: req_ready rose while full, want 0");
    end
    rsp_ready = 1'b1;
    push_req(mk(0, 8'h01, 8'h00, 0, 2, 0));
    wait_drain(300);
    checks++;
    if (rsp_seen - base !== 6) begin
      errors++;
      $display("FAIL fill_count: got %0d want 6", rsp_seen - base);
    end
  endtask

  task automatic test_error();
    rsp_ready = 1'b1;
    push_req(mk(0, 8'h03, 8'h00, 1, 2, 0));
    push_req(mk(1, 8'h07, 8'h77, 0, 2, 0));
    push_req(mk(0, 8'h07, 8'h00, 0, 1, 0));
    push_req(mk(1, 8'h03, 8'hEE, 1, 3, 0));
    push_req(mk(0, 8'h03, 8'h00, 0, 1, 0));
    wait_drain(300);
  endtask

  task automatic test_backpressure();
    logic [10:0] snap;
    bit          stable = 1;
    int          n = 0;
    rsp_ready = 1'b0;
    push_req(mk(0, 8'h02, 8'h00, 0, 2, 0));
    push_req(mk(1, 8'h09, 8'h99, 0, 1, 0));
    while (!rsp_valid_o && n < 100) begin tick(); n++; end
    checks++;
    if (rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: got %b want 1", rsp_valid_o);
    end
    snap = {rsp_valid_o, rsp_wr_o, rsp_err_o, rsp_data_o};
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({rsp_valid_o, rsp_wr_o, rsp_err_o, rsp_data_o, spi_rst_o} !== {snap, 1'b1}) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable: got %h want %h", {rsp_valid_o, rsp_wr_o, rsp_err_o, rsp_data_o, spi_rst_o}, {snap, 1'b1});
    end
    rsp_ready = 1'b1;
    wait_drain(200);
  endtask

  task automatic test_reset_mid_wait();
    logic [29:0] want;
    bit          ok;
    bit          quiet = 1;
    int          base;
    want = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    rsp_ready = 1'b1;
    push_req(mk(1, 8'h04, 8'hDD, 0, 20, 0));
    push_req(mk(1, 8'h05, 8'hEE, 0, 1, 0));
    push_req(mk(0, 8'h04, 8'h00, 0, 1, 0));
    wait_launch(ok);
    tick();
    rst = 1'b1;
    launch_q.delete();
    exp_q.delete();
    base = rsp_seen;
    tick();
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL midwait_reset_values: got %h want %h", outs(), want);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0 || spi_rst_o !== 1'b1) quiet = 0;
    end
    checks++;
    if (!quiet || rsp_seen != base) begin
      errors++;
      $display("FAIL midwait_dropped: got %0d responses/activity=%b want 0/0", rsp_seen - base, !quiet);
    end
    push_req(mk(0, 8'h04, 8'h00, 0, 2, 0));
    push_req(mk(0, 8'h05, 8'h00, 0, 2, 0));
    wait_drain(200);
  endtask

  task automatic test_random();
    txn_t t;
    rand_rdy = 1; spurious_en = 1;
    for (int i = 0; i < 40; i++) begin
      t = mk(1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom),
             ($urandom_range(7) == 0), int'($urandom_range(5, 1)), 0);
      push_req(t);
      repeat ($urandom_range(3)) tick();
    end
    wait_drain(3000);
    rand_rdy = 0; spurious_en = 0;
    rsp_ready = 1'b1;
    tick();
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n = 0;
    rsp_ready = 1'b1;
    push_req(mk(0, 8'h01, 8'h00, 0, TO, 0));
    wait_drain(200);
    push_req(mk(0, 8'h02, 8'h00, 0, 1, 1));
    wait_launch(ok);
    while (!rsp_valid_o && n < 200) begin tick(); n++; end
    checks++;
    if (n - 1 !== TO || rsp_err_o !== 1'b1 || spi_rst_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_timing: got cycles=%0d err=%b spi_rst=%b want %0d/1/1",
               n - 1, rsp_err_o, spi_rst_o, TO);
    end
    wait_drain(100);
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    bit quiet = 1;
    rsp_ready = 1'b1;
    push_req(mk(0, 8'h03, 8'h00, 0, 60, 0));
    wait_launch(ok);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL no_timeout_wait: rsp_valid rose early, want 0");
    end
    wait_drain(100);
  endtask
`endif

  initial begin : main
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_write_read();
    test_fill();
    test_error();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
